// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Takes a 16-bit big-endian word count followed by a byte stream, packs the
// bytes big-endian into 32-bit words, and writes them to consecutive word
// addresses starting at BASE_ADDR while holding the processor stalled.
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
// byte_ready depends only on the current state, never on byte_valid, and the
// upstream source may hold or drop byte_valid freely without losing data.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [15:0] idx_next;
    logic [1:0]  byte_idx_q;
    logic [23:0] partial_q;
    logic [15:0] len_full;
    logic        len_too_big;
    logic        xfer;

    // The full count is only meaningful while the low length byte is presented.
    assign len_full    = {count_q[15:8], byte_in};
    assign len_too_big = ({16'd0, len_full} > 32'(MAX_WORDS));
    assign idx_next    = word_idx_q + 16'd1;
    assign xfer        = byte_valid && byte_ready;
    assign dbg_state   = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived control outputs.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len_full == 16'd0 || len_too_big) state_d = S_DONE;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_idx_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (idx_next == count_q) state_d = S_DONE;
                else                     state_d = S_DATA;
            end
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Length capture, word assembly, write address/data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 16'd0;
            word_idx_q <= 16'd0;
            byte_idx_q <= 2'd0;
            partial_q  <= 24'd0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err        <= 1'b0;
                        word_idx_q <= 16'd0;
                        byte_idx_q <= 2'd0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) count_q[15:8] <= byte_in;
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        count_q[7:0] <= byte_in;
                        if (len_too_big) err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: partial_q[23:16] <= byte_in;
                            2'd1: partial_q[15:8]  <= byte_in;
                            2'd2: partial_q[7:0]   <= byte_in;
                            default: begin
                                // Address and data are staged here so they are
                                // valid exactly in the single WRITE cycle.
                                mem_wdata <= {partial_q, byte_in};
                                mem_addr  <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx_q <= idx_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// loads, compared cycle by cycle against a byte-counting reference model.
module tb_imem_loader;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MAX_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Writes observed on the memory port, and writes the test expects.
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Counts accepted bytes since start: two length bytes, then data bytes
    // grouped by four; each full group produces one write the following cycle.
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    int          m_n = 0;
    int          m_words = 0;
    logic [15:0] m_len = 0;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_addr = 0;
    logic [31:0] m_data = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_done = 0; m_err = 0; m_we = 0;
            m_n = 0; m_words = 0; m_bytes.delete();
        end else if (m_we) begin
            m_we = 0;
            m_words++;
            if (m_words == int'(m_len)) begin m_active = 0; m_done = 1; end
        end else if (m_active) begin
            if (byte_valid) begin
                if (m_n == 0) m_len[15:8] = byte_in;
                else if (m_n == 1) begin
                    m_len[7:0] = byte_in;
                    if (m_len == 0) begin m_active = 0; m_done = 1; end
                    else if (int'(m_len) > MAX_WORDS) begin m_active = 0; m_done = 1; m_err = 1; end
                end else begin
                    m_bytes.push_back(byte_in);
                    if (m_bytes.size() == 4) begin
                        m_we   = 1;
                        m_addr = BASE + 32'(4 * m_words);
                        m_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        m_bytes.delete();
                    end
                end
                m_n++;
            end
        end else if (start) begin
            m_active = 1; m_done = 0; m_err = 0;
            m_n = 0; m_words = 0; m_bytes.delete();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("byte_ready", {31'd0, byte_ready}, {31'd0, m_active && !m_we});
            check("mem_we",     {31'd0, mem_we},     {31'd0, m_we});
            check("cpu_hold",   {31'd0, cpu_hold},   {31'd0, !m_done});
            check("done",       {31'd0, done},       {31'd0, m_done});
            check("err",        {31'd0, err},        {31'd0, m_err});
            if (m_we) begin
                check("mem_addr",  mem_addr,  m_addr);
                check("mem_wdata", mem_wdata, m_data);
            end
            if (mem_we) got_q.push_back({mem_addr, mem_wdata});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte until it is accepted, then idle for 'gap' cycles with
    // garbage on byte_in. 'noise_start' raises start alongside the byte.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise_start);
        int t;
        t = 0;
        byte_in = b; byte_valid = 1'b1; start = noise_start;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("handshake_ready", {31'd0, byte_ready}, 32'd1);
        if (byte_ready) @(negedge clk);
        byte_valid = 1'b0; start = 1'b0;
        repeat (gap) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_writes(input string name);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({name, "_addr"}, got_q[i][63:32], exp_q[i][63:32]);
            check({name, "_data"}, got_q[i][31:0],  exp_q[i][31:0]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Send a load: length header then data bytes, random gaps up to max_gap.
    task automatic send_load(input logic [15:0] len, input logic [7:0] data[$], input int max_gap, input bit noisy);
        send_byte(len[15:8], $urandom_range(0, max_gap), 1'b0);
        send_byte(len[7:0],  $urandom_range(0, max_gap), 1'b0);
        foreach (data[i])
            send_byte(data[i], $urandom_range(0, max_gap), noisy && ($urandom_range(0, 3) == 0));
    endtask

    logic [7:0] stream[$];
    logic [7:0] tmp;

    initial begin
        do_reset();

        // Reset state.
        check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_err",        {31'd0, err},        32'd0);
        check("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_mem_addr",   mem_addr,            BASE);
        check("rst_mem_wdata",  mem_wdata,           32'd0);

        // Two-word image, back-to-back bytes.
        stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        pulse_start();
        send_load(16'd2, stream, 0, 1'b0);
        wait_done(20);
        exp_q.push_back({32'h0, 32'h2008_0005});
        exp_q.push_back({32'h4, 32'h0109_5020});
        check_writes("two_word");
        check("two_word_hold", {31'd0, cpu_hold}, 32'd0);

        // Same image with 3-cycle gaps after each byte, restarted from DONE.
        pulse_start();
        send_byte(8'h00, 3, 1'b0);
        send_byte(8'h02, 3, 1'b0);
        foreach (stream[i]) begin
            send_byte(stream[i], 3, 1'b0);
            if (i % 4 != 3) check("gap_no_write", 32'(got_q.size()), 32'(i / 4));
        end
        wait_done(20);
        exp_q.push_back({32'h0, 32'h2008_0005});
        exp_q.push_back({32'h4, 32'h0109_5020});
        check_writes("gapped");

        // Zero count: done right after the second length byte, no writes.
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_err",  {31'd0, err},  32'd0);
        check("zero_hold", {31'd0, cpu_hold}, 32'd0);
        check_writes("zero");

        // Oversized count (257): error, no writes, later bytes refused.
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        check("big_done", {31'd0, done}, 32'd1);
        check("big_err",  {31'd0, err},  32'd1);
        byte_in = 8'hAA; byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        byte_valid = 1'b0;
        check("big_ready", {31'd0, byte_ready}, 32'd0);
        check_writes("big");

        // Reset in the middle of a 3-word load, then a 1-word load.
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_hold",  {31'd0, cpu_hold},   32'd1);
        check("midrst_done",  {31'd0, done},       32'd0);
        check("midrst_ready", {31'd0, byte_ready}, 32'd0);
        check("midrst_wdata", mem_wdata,           32'd0);
        pulse_start();
        stream = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_load(16'd1, stream, 1, 1'b0);
        wait_done(20);
        exp_q.push_back({32'h0, 32'h1234_5678});
        check_writes("after_rst");

        // Restart from DONE with start pulses during DATA.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart_done", {31'd0, done},     32'd0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b1);
        send_byte(8'hBB, 1, 1'b1);
        pulse_start();
        send_byte(8'hCC, 0, 1'b1);
        send_byte(8'hDD, 0, 1'b0);
        wait_done(20);
        check("restart_done2", {31'd0, done}, 32'd1);
        exp_q.push_back({32'h0, 32'hAABB_CCDD});
        check_writes("restart");

        // Randomized loads with gaps and stray start pulses.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 6);
            stream.delete();
            for (int w = 0; w < len; w++) begin
                logic [31:0] word;
                for (int k = 0; k < 4; k++) begin
                    tmp = 8'($urandom);
                    stream.push_back(tmp);
                    word = {word[23:0], tmp};
                end
                exp_q.push_back({BASE + 32'(4 * w), word});
            end
            pulse_start();
            send_load(16'(len), stream, 2, 1'b1);
            wait_done(40);
            check_writes("random");
        end

        // Exactly MAX_WORDS words: accepted, last word at the top address.
        stream.delete();
        for (int w = 0; w < MAX_WORDS; w++) begin
            logic [31:0] word;
            word = $urandom;
            for (int k = 3; k >= 0; k--) begin
                tmp = word[8*k +: 8];
                stream.push_back(tmp);
            end
            exp_q.push_back({BASE + 32'(4 * w), word});
        end
        pulse_start();
        send_load(16'(MAX_WORDS), stream, 0, 1'b0);
        wait_done(40);
        check("max_err", {31'd0, err}, 32'd0);
        if (got_q.size() > 0) check("max_last_addr", got_q[got_q.size() - 1][63:32], 32'h3FC);
        check_writes("max_words");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
